mag_stats: RTL and testbench
============================

MAG_STATS -- requirements
Module: mag_stats

Interface
REQ-001 Parameter WIN_LOG2, default 3: log2 of the averaging window length N (N = 2^WIN_LOG2).
REQ-002 Parameter HYST, default 4: alarm release hysteresis in magnitude LSBs.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mag_in  input  8  magnitude sample from the upstream sqrt(x^2+y^2) stage.
REQ-006 mag_valid  input  1  one-cycle strobe; mag_in is accepted when it is high.
REQ-007 thresh  input  8  alarm threshold, sampled at every evaluation.
REQ-008 clr_peak  input  1  clears the peak hold.
REQ-009 avg_out  output  8  registered moving average of the last N samples.
REQ-010 avg_valid  output  1  one-cycle pulse when avg_out holds a full-window average.
REQ-011 peak_out  output  8  registered maximum sample since reset or the last clr_peak.
REQ-012 alarm  output  1  registered output of the alarm state machine.

Function
REQ-013 The block SHALL hold an N-entry x 8-bit circular buffer, a write pointer and a running sum of 8+WIN_LOG2 bits.
REQ-014 On each accepted sample: sum <= sum + mag_in - buf[wptr]; buf[wptr] <= mag_in; wptr increments modulo N.
REQ-015 The running sum SHALL never overflow or underflow, because it equals the exact sum of the buffer contents.
REQ-016 A fill counter SHALL increment per accepted sample and saturate at N.
REQ-017 avg_out SHALL update in the cycle after acceptance, to (new sum) >> WIN_LOG2, truncated.
REQ-018 avg_out SHALL update on every accepted sample, including before the buffer is full.
REQ-019 avg_valid SHALL pulse in the cycle after acceptance only when the fill counter reaches or already equals N after that acceptance.
REQ-020 avg_valid SHALL be low in all other cycles.
REQ-021 Latency: 1 cycle from mag_valid to avg_out, avg_valid, peak_out and alarm.
REQ-022 Back-to-back samples on consecutive cycles SHALL be accepted with no stall; the block has no ready output.
REQ-023 Peak: on acceptance, peak_out <= max(peak_out, mag_in).
REQ-024 clr_peak alone SHALL set peak_out <= 0.
REQ-025 If clr_peak and mag_valid are high in the same cycle, peak_out <= mag_in.
REQ-026 The alarm FSM SHALL have three states: BELOW (alarm=0), PENDING (alarm=0) and ABOVE (alarm=1).
REQ-027 The FSM SHALL evaluate only on cycles where a full-window average is computed (the accepting cycle of REQ-019), using the new average A.
REQ-028 BELOW SHALL go to PENDING if A >= thresh, else stay in BELOW.
REQ-029 PENDING SHALL go to ABOVE if A >= thresh, else return to BELOW.
REQ-030 ABOVE SHALL go to BELOW if A < rel, where rel = thresh - HYST saturated at 0, else stay in ABOVE.
REQ-031 With thresh <= HYST, rel = 0 and ABOVE SHALL never release except by reset.
REQ-032 The FSM SHALL hold its state on non-evaluation cycles.
REQ-033 alarm SHALL reflect the new state in the cycle after evaluation.
REQ-034 thresh changes SHALL take effect at the next evaluation only.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL clear all buffer entries, sum, wptr and fill counter to 0.
REQ-036 While rst=1 at a clock edge, avg_out=0, avg_valid=0, peak_out=0, alarm=0 and FSM=BELOW.
REQ-037 rst SHALL override mag_valid and clr_peak in the same cycle.
REQ-038 Reset mid-window SHALL discard partial data; the next full average requires N new samples.

Verification
REQ-039 Eight samples of 5 (WIN_LOG2=3) -> avg_out=5 and avg_valid pulses only after the 8th sample; avg_valid is low after samples 1-7 (e.g. avg_out=0 after sample 1, 1 after sample 2).
REQ-040 Then one sample of 13 -> sum 48, avg_out=6, avg_valid pulses again; then 7 more 13s -> avg_out=13.
REQ-041 Samples 3, 200, 7 -> peak_out 3, 200, 200; clr_peak with mag_valid=9 -> peak_out=9; clr_peak alone -> 0.
REQ-042 thresh=10, HYST=4, full-window averages 10, 10, 7, 5 -> alarm 0, 1, 1, 0; a single average of 10 followed by 9 -> alarm remains 0.
REQ-043 thresh=3, HYST=4, averages 3, 3, then 0 -> alarm latches at 1 and stays 1.
REQ-044 rst pulse after 5 of 8 samples, then 7 more samples -> no avg_valid, alarm=0; the 8th sample produces the first avg_valid.

Source files
------------

// File: rtl/mag_stats.sv
// -----------------------------------------------------------------------------
// mag_stats
//
// Running statistics over a stream of 8-bit magnitude samples:
//   * moving average over the last N = 2^WIN_LOG2 accepted samples,
//   * peak hold since reset or the last clr_peak,
//   * a three-state threshold alarm with release hysteresis.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous, active-high reset
//   mag_in     magnitude sample, accepted when mag_valid is high
//   mag_valid  one-cycle acceptance strobe (no back-pressure)
//   thresh     alarm threshold, sampled at every alarm evaluation
//   clr_peak   clears the peak hold (or loads mag_in if a sample arrives too)
//   avg_out    registered moving average, updated on every accepted sample
//   avg_valid  one-cycle pulse when avg_out holds a full-window average
//   peak_out   registered maximum sample
//   alarm      registered alarm-state output
//
// All outputs change one cycle after the accepting edge.
// -----------------------------------------------------------------------------
module mag_stats #(
  parameter int WIN_LOG2 = 3,
  parameter int HYST     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mag_in,
  input  logic       mag_valid,
  input  logic [7:0] thresh,
  input  logic       clr_peak,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic [7:0] peak_out,
  output logic       alarm
);

  localparam int N      = 1 << WIN_LOG2;
  localparam int SUM_W  = 8 + WIN_LOG2;
  localparam int FILL_W = WIN_LOG2 + 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  typedef enum logic [1:0] {
    ST_BELOW,
    ST_PENDING,
    ST_ABOVE
  } state_t;

  // Window storage and bookkeeping
  logic [7:0]          sample_buf [N];
  logic [WIN_LOG2-1:0] wptr_q;
  logic [SUM_W-1:0]    sum_q;
  logic [FILL_W-1:0]   fill_q;

  // Combinational next values
  logic [SUM_W-1:0]    sum_next;
  logic [FILL_W-1:0]   fill_next;
  logic [7:0]          avg_next;
  logic [7:0]          rel;
  logic                full_next;
  logic                eval;

  state_t              state_q;
  state_t              state_d;

  // The running sum always equals the exact sum of the buffer, so the
  // modular add/subtract below lands on the true value and never wraps.
  assign sum_next  = sum_q + SUM_W'(mag_in) - SUM_W'(sample_buf[wptr_q]);
  assign avg_next  = sum_next[SUM_W-1:WIN_LOG2];

  // Fill counter saturates at N; a full-window average exists once it is N.
  assign fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
  assign full_next = (fill_next == FILL_FULL);
  assign eval      = mag_valid && full_next;

  // Release level: thresh - HYST, clamped at zero. With rel = 0 the
  // "A < rel" release can never fire, so ABOVE only leaves via reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    rel = '0;
    if (int'(thresh) > HYST) rel = 8'(int'(thresh) - HYST);
  end

  // ---------------------------------------------------------------------------
  // Window datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer is cleared on reset on purpose: the running sum is
      // reset to 0, so the entries it subtracts later must be 0 as well.
      for (int i = 0; i < N; i++) sample_buf[i] <= '0;
      wptr_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (mag_valid) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; sum_next reads the old sample_buf[wptr_q].
      sample_buf[wptr_q] <= mag_in;
      sum_q              <= sum_next;
      wptr_q             <= wptr_q + WIN_LOG2'(1);
      fill_q             <= fill_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: average, valid pulse, peak hold, alarm
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
      peak_out  <= '0;
      alarm     <= 1'b0;
    end else begin
      avg_valid <= eval;
      if (mag_valid) avg_out <= avg_next;

      // A sample arriving with clr_peak starts the new peak at that sample.
      if (clr_peak) begin
        peak_out <= mag_valid ? mag_in : '0;
      end else if (mag_valid && (mag_in > peak_out)) begin
        peak_out <= mag_in;
      end

      alarm <= (state_d == ST_ABOVE);
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm FSM: evaluates only when a full-window average is produced
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BELOW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (eval) begin
      case (state_q)
        ST_BELOW:   state_d = (avg_next >= thresh) ? ST_PENDING : ST_BELOW;
        ST_PENDING: state_d = (avg_next >= thresh) ? ST_ABOVE   : ST_BELOW;
        ST_ABOVE:   state_d = (avg_next <  rel)    ? ST_BELOW   : ST_ABOVE;
        default:    state_d = ST_BELOW;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_stats.sv
// -----------------------------------------------------------------------------
// tb_mag_stats
//
// Directed bench for mag_stats (WIN_LOG2 = 3, HYST = 4). A queue-based model
// of the last N samples predicts every output; a compare process checks the
// DUT against it on each falling edge. Literal expectations worked out by hand
// are checked along the directed sequence to pin the model itself.
// -----------------------------------------------------------------------------
module tb_mag_stats;

  localparam int WIN_LOG2 = 3;
  localparam int HYST     = 4;
  localparam int N        = 1 << WIN_LOG2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] mag_in    = '0;
  logic       mag_valid = 1'b0;
  logic [7:0] thresh    = '0;
  logic       clr_peak  = 1'b0;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic [7:0] peak_out;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  mag_stats #(.WIN_LOG2(WIN_LOG2), .HYST(HYST)) dut (
    .clk       (clk),
    .rst       (rst),
    .mag_in    (mag_in),
    .mag_valid (mag_valid),
    .thresh    (thresh),
    .clr_peak  (clr_peak),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .peak_out  (peak_out),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keep the last N accepted samples, derive everything from
  // them with plain arithmetic. Alarm state: 0 = below, 1 = pending, 2 = above.
  // ---------------------------------------------------------------------------
  int  win[$];
  int  m_avg   = 0;
  bit  m_valid = 1'b0;
  int  m_peak  = 0;
  int  m_state = 0;
  bit  model_live = 1'b0;

  always @(posedge clk) begin
    int s;
    int release_lvl;
    model_live = 1'b1;
    if (rst) begin
      win.delete();
      m_avg   = 0;
      m_valid = 1'b0;
      m_peak  = 0;
      m_state = 0;
    end else begin
      m_valid = 1'b0;
      if (mag_valid) begin
        win.push_back(int'(mag_in));
        if (win.size() > N) void'(win.pop_front());
        s = 0;
        foreach (win[i]) s += win[i];
        m_avg = s / N;
        if (win.size() == N) begin
          m_valid = 1'b1;
          release_lvl = (int'(thresh) > HYST) ? int'(thresh) - HYST : 0;
          case (m_state)
            0:       m_state = (m_avg >= int'(thresh)) ? 1 : 0;
            1:       m_state = (m_avg >= int'(thresh)) ? 2 : 0;
            default: m_state = (m_avg < release_lvl)   ? 0 : 2;
          endcase
        end
      end
      if (clr_peak)                                 m_peak = mag_valid ? int'(mag_in) : 0;
      else if (mag_valid && int'(mag_in) > m_peak)  m_peak = int'(mag_in);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_avg_out",   avg_out,   m_avg);
      check("cmp_avg_valid", avg_valid, m_valid);
      check("cmp_peak_out",  peak_out,  m_peak);
      check("cmp_alarm",     alarm,     (m_state == 2) ? 1 : 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each starts and ends on a falling edge
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] v, input bit clr = 1'b0);
    mag_in    = v;
    mag_valid = 1'b1;
    clr_peak  = clr;
    @(negedge clk);
    mag_valid = 1'b0;
    clr_peak  = 1'b0;
  endtask

  task automatic clr_only();
    clr_peak = 1'b1;
    @(negedge clk);
    clr_peak = 1'b0;
  endtask

  // Optionally pile a sample and clr_peak onto the reset cycle; reset wins.
  task automatic do_reset(input bit with_traffic);
    rst       = 1'b1;
    mag_in    = 8'd99;
    mag_valid = with_traffic;
    clr_peak  = with_traffic;
    @(negedge clk);
    rst       = 1'b0;
    mag_valid = 1'b0;
    clr_peak  = 1'b0;
  endtask

  // Fill pattern giving full-window averages 10, 10, 7, 5 with the
  // follow-up samples 0, 6, 4 (sums 80, 80, 56, 40).
  logic [7:0] alarm_fill [8] = '{8'd0, 8'd30, 8'd20, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};

  initial begin
    thresh = 8'd200;
    repeat (2) @(negedge clk);
    check("reset_avg_out",   avg_out,   0);
    check("reset_avg_valid", avg_valid, 0);
    check("reset_peak_out",  peak_out,  0);
    check("reset_alarm",     alarm,     0);
    rst = 1'b0;

    // Eight 5s: average builds up, valid only after the 8th.
    send(8'd5);
    check("s1_avg_out",   avg_out,   0);
    check("s1_avg_valid", avg_valid, 0);
    send(8'd5);
    check("s2_avg_out",   avg_out,   1);
    repeat (5) send(8'd5);
    check("s7_avg_valid", avg_valid, 0);
    send(8'd5);
    check("s8_avg_out",   avg_out,   5);
    check("s8_avg_valid", avg_valid, 1);
    @(negedge clk);
    check("idle_avg_valid", avg_valid, 0);

    // One 13 replaces a 5: sum 48 -> 6; seven more 13s -> 13 (back-to-back).
    send(8'd13);
    check("s9_avg_out",   avg_out,   6);
    check("s9_avg_valid", avg_valid, 1);
    repeat (7) send(8'd13);
    check("s16_avg_out",  avg_out,   13);

    // Peak hold.
    clr_only();
    check("peak_clr0", peak_out, 0);
    send(8'd3);
    check("peak_3",    peak_out, 3);
    send(8'd200);
    check("peak_200",  peak_out, 200);
    send(8'd7);
    check("peak_hold", peak_out, 200);
    send(8'd9, 1'b1);
    check("peak_clr_load", peak_out, 9);
    clr_only();
    check("peak_clr1", peak_out, 0);

    // Alarm: averages 10, 10, 7, 5 -> 0, 1, 1, 0 with thresh 10, rel 6.
    do_reset(1'b0);
    thresh = 8'd10;
    for (int i = 0; i < 8; i++) send(alarm_fill[i]);
    check("al_a1_avg",   avg_out, 10);
    check("al_a1_alarm", alarm,   0);
    send(8'd0);
    check("al_a2_alarm", alarm,   1);
    send(8'd6);
    check("al_a3_avg",   avg_out, 7);
    check("al_a3_alarm", alarm,   1);
    send(8'd4);
    check("al_a4_avg",   avg_out, 5);
    check("al_a4_alarm", alarm,   0);
    // Single 10 then 9: pending drops back, alarm never rises.
    send(8'd46);
    check("al_b1_avg",   avg_out, 10);
    check("al_b1_alarm", alarm,   0);
    send(8'd0);
    check("al_b2_avg",   avg_out, 9);
    check("al_b2_alarm", alarm,   0);

    // thresh <= HYST: once above, the alarm never releases.
    do_reset(1'b0);
    thresh = 8'd3;
    repeat (8) send(8'd3);
    check("lat_a1_alarm", alarm, 0);
    send(8'd3);
    check("lat_a2_alarm", alarm, 1);
    repeat (8) send(8'd0);
    check("lat_end_avg",   avg_out, 0);
    check("lat_end_alarm", alarm,   1);

    // Reset mid-window discards partial data; reset beats sample/clr_peak.
    do_reset(1'b0);
    repeat (5) send(8'd5);
    do_reset(1'b1);
    check("mid_rst_peak",  peak_out,  0);
    check("mid_rst_avg",   avg_out,   0);
    check("mid_rst_valid", avg_valid, 0);
    for (int i = 0; i < 7; i++) begin
      send(8'd5);
      check("mid_partial_valid", avg_valid, 0);
      check("mid_partial_alarm", alarm,     0);
    end
    send(8'd5);
    check("mid_full_valid", avg_valid, 1);
    check("mid_full_avg",   avg_out,   5);
    check("mid_full_alarm", alarm,     0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
